// File: rtl/c5_pkg.sv
// rtl/c5_pkg.sv - shared states, port ids and constants for the c5 memory arbiter
package c5_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } arb_state_t;

    localparam logic ARB_CPU = 1'b0;
    localparam logic ARB_DMA = 1'b1;

    localparam logic [31:0] C5_ERR_RDATA = 32'hDEADBEEF;

    localparam int BURST_W = 8;

endpackage

// File: rtl/c5_arb_pick.sv
// rtl/c5_arb_pick.sv - winner selection and CPU burst-counter next state
module c5_arb_pick
    import c5_pkg::*;
#(
    parameter int CPU_BURST_MAX = 4
)(
    input  logic               req0,
    input  logic               req1,
    input  logic [BURST_W-1:0] burst_cnt,
    output logic               grant,
    output logic [BURST_W-1:0] next_cnt
);

    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(CPU_BURST_MAX);

    // The count only grows while the DMA port is waiting, so it never passes the limit.
    always_comb begin
        grant    = ARB_CPU;
        next_cnt = '0;
        if (req1 && (!req0 || burst_cnt >= BURST_LIMIT)) begin
            grant = ARB_DMA;
        end
        if (req0 && req1 && grant == ARB_CPU) begin
            next_cnt = burst_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/c5_mem_arbiter.sv
// rtl/c5_mem_arbiter.sv - two-port memory arbiter (CPU/DMA) with a single outstanding access
// Optional wait-for-ack timeout enabled by defining C5_ARB_TIMEOUT_EN.
module c5_mem_arbiter
    import c5_pkg::*;
#(
    parameter int CPU_BURST_MAX  = 4,
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_req0,
    input  logic [29:0] I_addr0,
    input  logic [3:0]  I_we0,
    input  logic [31:0] I_wdata0,
    output logic [31:0] O_rdata0,
    output logic        O_ack0,
    output logic        O_cpu_pause,
    input  logic        I_req1,
    input  logic [29:0] I_addr1,
    input  logic [3:0]  I_we1,
    input  logic [31:0] I_wdata1,
    output logic [31:0] O_rdata1,
    output logic        O_ack1,
    output logic        O_mem_req,
    output logic [29:0] O_mem_addr,
    output logic [3:0]  O_mem_we,
    output logic [31:0] O_mem_wdata,
    input  logic        I_mem_ack,
    input  logic [31:0] I_mem_rdata,
    output logic        O_err
);

    arb_state_t         state;
    logic               winner;
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] next_cnt;
    logic               pick_grant;
    logic               done_now;
    logic [31:0]        done_rdata;

    c5_arb_pick #(
        .CPU_BURST_MAX(CPU_BURST_MAX)
    ) u_pick (
        .req0      (I_req0),
        .req1      (I_req1),
        .burst_cnt (burst_cnt),
        .grant     (pick_grant),
        .next_cnt  (next_cnt)
    );

    assign O_cpu_pause = I_req0 & ~O_ack0;

`ifdef C5_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES));
    // A real ack in the timeout cycle still returns the memory data.
    assign done_now    = I_mem_ack | timeout_hit;
    assign done_rdata  = I_mem_ack ? I_mem_rdata : C5_ERR_RDATA;
`else
    assign done_now    = I_mem_ack;
    assign done_rdata  = I_mem_rdata;
    assign O_err       = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= S_IDLE;
            winner      <= ARB_CPU;
            burst_cnt   <= '0;
            O_mem_req   <= 1'b0;
            O_mem_addr  <= '0;
            O_mem_we    <= '0;
            O_mem_wdata <= '0;
            O_ack0      <= 1'b0;
            O_ack1      <= 1'b0;
            O_rdata0    <= '0;
            O_rdata1    <= '0;
`ifdef C5_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            O_err       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    burst_cnt <= next_cnt;
`ifdef C5_ARB_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                    if (I_req0 || I_req1) begin
                        winner      <= pick_grant;
                        O_mem_req   <= 1'b1;
                        O_mem_addr  <= (pick_grant == ARB_DMA) ? I_addr1  : I_addr0;
                        O_mem_we    <= (pick_grant == ARB_DMA) ? I_we1    : I_we0;
                        O_mem_wdata <= (pick_grant == ARB_DMA) ? I_wdata1 : I_wdata0;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef C5_ARB_TIMEOUT_EN
                    wait_cnt <= wait_cnt + 1'b1;
`endif
                    if (done_now) begin
                        O_mem_req <= 1'b0;
                        if (winner == ARB_DMA) begin
                            O_ack1   <= 1'b1;
                            O_rdata1 <= done_rdata;
                        end else begin
                            O_ack0   <= 1'b1;
                            O_rdata0 <= done_rdata;
                        end
`ifdef C5_ARB_TIMEOUT_EN
                        if (!I_mem_ack) begin
                            O_err <= 1'b1;
                        end
`endif
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    O_ack0 <= 1'b0;
                    O_ack1 <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c5_mem_arbiter.sv
// tb/tb_c5_mem_arbiter.sv - self-checking bench for c5_mem_arbiter with a transaction-level model
module tb_c5_mem_arbiter;

    localparam int BURST_MAX = 4;
    localparam int TOUT      = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [29:0] addr0 = '0, addr1 = '0;
    logic [3:0]  we0 = '0, we1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] rdata0, rdata1, mem_wdata;
    logic        ack0, ack1, cpu_pause, mem_req, err;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;

    int vectors = 0;
    int miscompares = 0;

    c5_mem_arbiter #(.CPU_BURST_MAX(BURST_MAX), .TIMEOUT_CYCLES(TOUT)) dut (
        .I_clk(clk), .I_rst_n(rst_n),
        .I_req0(req0), .I_addr0(addr0), .I_we0(we0), .I_wdata0(wdata0),
        .O_rdata0(rdata0), .O_ack0(ack0), .O_cpu_pause(cpu_pause),
        .I_req1(req1), .I_addr1(addr1), .I_we1(we1), .I_wdata1(wdata1),
        .O_rdata1(rdata1), .O_ack1(ack1),
        .O_mem_req(mem_req), .O_mem_addr(mem_addr), .O_mem_we(mem_we), .O_mem_wdata(mem_wdata),
        .I_mem_ack(mem_ack), .I_mem_rdata(mem_rdata), .O_err(err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({mem_req, ack0, ack1, err, cpu_pause, mem_we} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b exp 0", {mem_req, ack0, ack1, err, cpu_pause, mem_we});
        end
        vectors++;
        if ({rdata0, rdata1, mem_wdata, mem_addr} !== 126'd0) begin
            miscompares++;
            $display("FAIL reset_data got %h exp 0", {rdata0, rdata1, mem_wdata, mem_addr});
        end
        req0 = 1'b1;
        #1;
        vectors++;
        if (cpu_pause !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pause got %b exp 1", cpu_pause);
        end
        req0 = 1'b0;
    endtask

    task automatic test_cpu_read();
        do_reset();
        req0 = 1'b1; addr0 = 30'h40; we0 = 4'd0; wdata0 = $urandom;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 30'h40 || mem_we !== 4'd0 || ack0 !== 1'b0 || cpu_pause !== 1'b1) begin
            miscompares++;
            $display("FAIL read_issue got req=%b addr=%h we=%h ack0=%b pause=%b exp 1 40 0 0 1",
                     mem_req, mem_addr, mem_we, ack0, cpu_pause);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || ack0 !== 1'b0) begin
            miscompares++;
            $display("FAIL read_wait got req=%b ack0=%b exp 1 0", mem_req, ack0);
        end
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        vectors++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata0 !== 32'h12345678 || cpu_pause !== 1'b0 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL read_ack got ack0=%b ack1=%b rdata0=%h pause=%b req=%b exp 1 0 12345678 0 0",
                     ack0, ack1, rdata0, cpu_pause, mem_req);
        end
        req0 = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (ack0 !== 1'b0 || rdata0 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL read_after got ack0=%b rdata0=%h exp 0 12345678", ack0, rdata0);
        end
    endtask

    task automatic test_burst();
        int order[$];
        int exp_order[$];
        int cnt;
        logic [31:0] last_rd;
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        addr0 = 30'($urandom); addr1 = 30'($urandom); we0 = 4'd0; we1 = 4'd0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (cnt == BURST_MAX) begin exp_order.push_back(1); cnt = 0; end
            else begin exp_order.push_back(0); cnt++; end
        end
        last_rd = '0;
        for (int c = 0; c < 100 && order.size() < 10; c++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                vectors++;
                if ((ack0 && ack1) || (ack0 ? rdata0 : rdata1) !== last_rd) begin
                    miscompares++;
                    $display("FAIL burst_ack got ack0=%b ack1=%b rd=%h exp one ack rd=%h",
                             ack0, ack1, ack0 ? rdata0 : rdata1, last_rd);
                end
                order.push_back(ack1 ? 1 : 0);
            end
            mem_ack = mem_req;
            mem_rdata = $urandom;
            last_rd = mem_rdata;
        end
        vectors++;
        if (order.size() != 10) begin
            miscompares++;
            $display("FAIL burst_count got %0d exp 10", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            vectors++;
            if (order[i] != exp_order[i]) begin
                miscompares++;
                $display("FAIL burst_order[%0d] got %0d exp %0d", i, order[i], exp_order[i]);
            end
        end
        req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic test_dma_write();
        logic [29:0] a;
        logic [31:0] d;
        do_reset();
        a = 30'($urandom);
        req1 = 1'b1; addr1 = a; we1 = 4'b0011; wdata1 = 32'hAABBCCDD;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (mem_req !== 1'b1 || mem_we !== 4'b0011 || mem_wdata !== 32'hAABBCCDD || mem_addr !== a || ack1 !== 1'b0) begin
                miscompares++;
                $display("FAIL dma_hold[%0d] got req=%b we=%b wd=%h addr=%h ack1=%b exp 1 0011 aabbccdd %h 0",
                         i, mem_req, mem_we, mem_wdata, mem_addr, ack1, a);
            end
            @(negedge clk);
        end
        d = $urandom;
        mem_ack = 1'b1; mem_rdata = d;
        @(negedge clk);
        vectors++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || mem_req !== 1'b0 || rdata1 !== d) begin
            miscompares++;
            $display("FAIL dma_ack got ack1=%b ack0=%b req=%b rd1=%h exp 1 0 0 %h", ack1, ack0, mem_req, rdata1, d);
        end
        req1 = 1'b0; mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (ack1 !== 1'b0 || ack0 !== 1'b0 || mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL dma_pulse[%0d] got ack1=%b ack0=%b req=%b exp 0 0 0", i, ack1, ack0, mem_req);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [29:0] a;
        logic [31:0] d;
        do_reset();
        req0 = 1'b1; addr0 = 30'($urandom); we0 = 4'd0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_drop got req=%b ack0=%b ack1=%b exp 0 0 0", mem_req, ack0, ack1);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        a = 30'($urandom); addr0 = a;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== a || ack0 !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_issue got req=%b addr=%h ack0=%b exp 1 %h 0", mem_req, mem_addr, ack0, a);
        end
        d = $urandom;
        mem_ack = 1'b1; mem_rdata = d;
        @(negedge clk);
        vectors++;
        if (ack0 !== 1'b1 || rdata0 !== d) begin
            miscompares++;
            $display("FAIL rstmid_ack got ack0=%b rd0=%h exp 1 %h", ack0, rdata0, d);
        end
        req0 = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spurious();
        logic [31:0] d;
        do_reset();
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 || rdata0 !== 32'd0) begin
            miscompares++;
            $display("FAIL spur_idle got req=%b ack0=%b ack1=%b rd0=%h exp 0 0 0 0", mem_req, ack0, ack1, rdata0);
        end
        mem_ack = 1'b0;
        req1 = 1'b1; addr1 = 30'($urandom); we1 = 4'hF; wdata1 = $urandom;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL spur_issue got req=%b exp 1", mem_req);
        end
        d = $urandom;
        mem_ack = 1'b1; mem_rdata = d;
        @(negedge clk);
        req1 = 1'b0; mem_rdata = ~d;
        @(negedge clk);
        vectors++;
        if (ack1 !== 1'b0 || ack0 !== 1'b0 || mem_req !== 1'b0 || rdata1 !== d) begin
            miscompares++;
            $display("FAIL spur_done got ack1=%b ack0=%b req=%b rd1=%h exp 0 0 0 %h", ack1, ack0, mem_req, rdata1, d);
        end
        @(negedge clk);
        vectors++;
        if (ack1 !== 1'b0 || mem_req !== 1'b0 || rdata1 !== d) begin
            miscompares++;
            $display("FAIL spur_idle2 got ack1=%b req=%b rd1=%h exp 0 0 %h", ack1, mem_req, rdata1, d);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        int          cnt_model, served, delay;
        logic        busy, ack_due, win, exp_pause;
        logic        a0, a1;
        logic [29:0] s_addr0, s_addr1, e_addr;
        logic [3:0]  s_we0, s_we1, e_we;
        logic [31:0] s_wd0, s_wd1, e_wd, ack_data, exp_rd0, exp_rd1;
        logic        acked0, acked1;
        do_reset();
        cnt_model = 0; served = 0; delay = 0;
        busy = 1'b0; ack_due = 1'b0; win = 1'b0;
        exp_rd0 = '0; exp_rd1 = '0; ack_data = '0;
        e_addr = '0; e_we = '0; e_wd = '0;
        for (int c = 0; c < 4000 && served < 60; c++) begin
            @(negedge clk);
            a0 = req0; a1 = req1;
            s_addr0 = addr0; s_addr1 = addr1; s_we0 = we0; s_we1 = we1; s_wd0 = wdata0; s_wd1 = wdata1;
            acked0 = 1'b0; acked1 = 1'b0;
            exp_pause = a0 & ~(ack_due & ~win);
            vectors++;
            if (cpu_pause !== exp_pause || err !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_pause c=%0d got pause=%b err=%b exp %b 0", c, cpu_pause, err, exp_pause);
            end
            if (ack_due) begin
                if (win) begin exp_rd1 = ack_data; acked1 = 1'b1; end
                else begin exp_rd0 = ack_data; acked0 = 1'b1; end
                vectors++;
                if (ack0 !== ~win || ack1 !== win || mem_req !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_ack c=%0d got ack0=%b ack1=%b req=%b exp port %0d", c, ack0, ack1, mem_req, win);
                end
                served++;
                ack_due = 1'b0;
                busy = 1'b0;
            end else begin
                vectors++;
                if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_noack c=%0d got ack0=%b ack1=%b exp 0 0", c, ack0, ack1);
                end
                if (!busy && mem_req === 1'b1) begin
                    if (a0 && a1) win = (cnt_model == BURST_MAX);
                    else win = a1;
                    cnt_model = (win || !a1) ? 0 : cnt_model + 1;
                    e_addr = win ? s_addr1 : s_addr0;
                    e_we   = win ? s_we1 : s_we0;
                    e_wd   = win ? s_wd1 : s_wd0;
                    busy = 1'b1;
                    delay = $urandom_range(0, 5);
                    vectors++;
                    if (!(a0 || a1) || mem_addr !== e_addr || mem_we !== e_we || mem_wdata !== e_wd) begin
                        miscompares++;
                        $display("FAIL rnd_grant c=%0d got addr=%h we=%h wd=%h exp port %0d addr=%h we=%h wd=%h",
                                 c, mem_addr, mem_we, mem_wdata, win, e_addr, e_we, e_wd);
                    end
                end else if (busy) begin
                    vectors++;
                    if (mem_req !== 1'b1 || mem_addr !== e_addr || mem_we !== e_we || mem_wdata !== e_wd) begin
                        miscompares++;
                        $display("FAIL rnd_hold c=%0d got req=%b addr=%h we=%h wd=%h exp 1 %h %h %h",
                                 c, mem_req, mem_addr, mem_we, mem_wdata, e_addr, e_we, e_wd);
                    end
                end
            end
            vectors++;
            if (rdata0 !== exp_rd0 || rdata1 !== exp_rd1) begin
                miscompares++;
                $display("FAIL rnd_rdata c=%0d got %h %h exp %h %h", c, rdata0, rdata1, exp_rd0, exp_rd1);
            end
            if (acked0) req0 = ($urandom_range(0, 1) == 1);
            else if (!req0) req0 = ($urandom_range(0, 2) == 0);
            if (acked0 || !a0) begin addr0 = 30'($urandom); we0 = 4'($urandom); wdata0 = $urandom; end
            if (acked1) req1 = ($urandom_range(0, 1) == 1);
            else if (!req1) req1 = ($urandom_range(0, 2) == 0);
            if (acked1 || !a1) begin addr1 = 30'($urandom); we1 = 4'($urandom); wdata1 = $urandom; end
            mem_rdata = $urandom;
            if (busy && delay == 0) begin
                mem_ack = 1'b1;
                ack_data = mem_rdata;
                ack_due = 1'b1;
            end else begin
                if (busy) delay--;
                mem_ack = !busy && ($urandom_range(0, 3) == 0);
            end
        end
        vectors++;
        if (served < 60) begin
            miscompares++;
            $display("FAIL rnd_served got %0d exp 60", served);
        end
        req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
    endtask

`ifdef C5_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        do_reset();
        req0 = 1'b1; addr0 = 30'($urandom); we0 = 4'd0;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL tout_issue got req=%b exp 1", mem_req);
        end
        lat = 0;
        while (ack0 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (lat != TOUT + 1 || rdata0 !== 32'hDEADBEEF || err !== 1'b1 || mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL tout_ack got lat=%0d rd0=%h err=%b req=%b exp %0d deadbeef 1 0",
                     lat, rdata0, err, mem_req, TOUT + 1);
        end
        req0 = 1'b0;
        req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        req1 = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL tout_sticky got err=%b exp 1", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_read();
        test_burst();
        test_dma_write();
        test_reset_mid();
        test_spurious();
        test_random();
`ifdef C5_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
